// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and constants for the store buffer.
//   SB_XLEN / SB_ADDR_W / SB_DEPTH : default data width, address width, depth
//   byte_offset_bits()              : byte-offset bits inside one data word
//   sb_entry_t                      : one buffered store {valid, waddr, data, be}
// The entry struct is sized by the package widths; the top checks at
// elaboration that its XLEN/ADDR_W agree with them.
package store_buffer_pkg;

    localparam int SB_XLEN   = 32;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DEPTH  = 4;

    function automatic int byte_offset_bits(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    localparam int SB_OFS = byte_offset_bits(SB_XLEN);
    localparam int SB_WA  = SB_ADDR_W - SB_OFS;   // word-address width
    localparam int SB_NB  = SB_XLEN / 8;          // byte lanes

    typedef struct packed {
        logic               valid;
        logic [SB_WA-1:0]   waddr;
        logic [SB_XLEN-1:0] data;
        logic [SB_NB-1:0]   be;
    } sb_entry_t;

endpackage

// File: rtl/sb_byte_forward.sv
// sb_byte_forward: combinational youngest-first per-lane forwarding select.
//   i_ent   : entry array (circular, oldest at i_head)
//   i_head  : index of the oldest entry
//   i_waddr : lookup word address
//   o_data  : per-lane byte from the youngest matching entry (0 if none)
//   o_mask  : lanes for which some entry supplied a byte
module sb_byte_forward
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] i_ent,
    input  logic [PW-1:0]         i_head,
    input  logic [SB_WA-1:0]      i_waddr,
    output logic [SB_XLEN-1:0]    o_data,
    output logic [SB_NB-1:0]      o_mask
);

    logic [PW-1:0] w_idx;

    // Walk oldest -> youngest so a later (younger) match overwrites an older
    // one. Valid entries are contiguous from the head, so invalid slots are
    // simply skipped.
    always_comb begin
        o_data = '0;
        o_mask = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            for (int l = 0; l < SB_NB; l++) begin
                if (i_ent[w_idx].valid && i_ent[w_idx].waddr == i_waddr && i_ent[w_idx].be[l]) begin
                    o_data[8*l +: 8] = i_ent[w_idx].data[8*l +: 8];
                    o_mask[l]        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry store FIFO between EX and data memory with
// per-byte enables and youngest-first store-to-load forwarding.
//   st_*   : store enqueue (valid/ready), byte address, lane-aligned data, be
//   ld_*   : combinational load lookup; ld_data/ld_hit/ld_partial
//   mem_*  : head entry toward memory, popped on mem_we && mem_ready
//   count/empty/full : occupancy
//   reset  : synchronous, active low; outputs read as idle while asserted
// Build option: define STORE_BUFFER_COALESCE_EN to merge a store into the
// youngest entry when both hit the same word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int XLEN   = SB_XLEN,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DEPTH  = SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [XLEN-1:0]          st_wdata,
    input  logic [XLEN/8-1:0]        st_be,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [XLEN/8-1:0]        ld_be,
    output logic [XLEN-1:0]          ld_data,
    output logic                     ld_hit,
    output logic                     ld_partial,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [XLEN/8-1:0]        mem_be,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int OFS = byte_offset_bits(XLEN);
    localparam int NB  = XLEN / 8;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    if (XLEN != SB_XLEN || ADDR_W != SB_ADDR_W || OFS != SB_OFS) begin : g_width_chk
        $error("store_buffer: XLEN/ADDR_W must match store_buffer_pkg");
    end
    if (DEPTH < 2 || DEPTH > 16 || (1 << PW) != DEPTH) begin : g_depth_chk
        $error("store_buffer: DEPTH must be a power of 2 in 2..16");
    end

    sb_entry_t [DEPTH-1:0] r_ent;
    logic [PW-1:0]         r_head, r_tail;
    logic [CW-1:0]         r_count;

    logic              w_empty, w_push, w_pop, w_merge, w_ld_on;
    logic [SB_WA-1:0]  w_st_waddr, w_ld_waddr;
    logic [XLEN-1:0]   w_fwd_data;
    logic [NB-1:0]     w_fwd_mask, w_cov;
    sb_entry_t         w_head_ent;
    logic              w_unused_ofs;

    assign w_st_waddr   = st_addr[ADDR_W-1:OFS];
    assign w_ld_waddr   = ld_addr[ADDR_W-1:OFS];
    assign w_unused_ofs = ^{st_addr[OFS-1:0], ld_addr[OFS-1:0]};

    // Occupancy flags are forced idle while reset is held so the core never
    // sees stale entries during the reset cycle.
    assign w_empty = (r_count == '0);
    assign empty   = w_empty || !reset;
    assign full    = (r_count == CW'(DEPTH)) && reset;
    assign count   = reset ? r_count : '0;

    assign w_head_ent = r_ent[r_head];
    assign mem_we     = !empty;
    assign mem_addr   = {w_head_ent.waddr, {OFS{1'b0}}};
    assign mem_wdata  = w_head_ent.data;
    assign mem_be     = w_head_ent.be;
    assign w_pop      = mem_we && mem_ready;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] w_young;
    logic          w_merge_ok;
    assign w_young = r_tail - PW'(1);
    // Never merge into a head that is leaving this cycle.
    assign w_merge_ok = !w_empty && r_ent[w_young].valid
                        && (r_ent[w_young].waddr == w_st_waddr)
                        && !((w_young == r_head) && w_pop);
    assign st_ready = !full || w_merge_ok;
    assign w_merge  = st_valid && w_merge_ok && reset;
`else
    assign st_ready = !full;
    assign w_merge  = 1'b0;
`endif

    assign w_push = st_valid && st_ready && !w_merge;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
        end else begin
            // push never lands on the popping slot: push needs !full, pop needs !empty
            if (w_push) begin
                r_ent[r_tail] <= sb_entry_t'{valid: 1'b1, waddr: w_st_waddr, data: st_wdata, be: st_be};
                r_tail        <= r_tail + PW'(1);
            end
`ifdef STORE_BUFFER_COALESCE_EN
            if (w_merge) begin
                for (int l = 0; l < NB; l++)
                    if (st_be[l]) r_ent[w_young].data[8*l +: 8] <= st_wdata[8*l +: 8];
                r_ent[w_young].be <= r_ent[w_young].be | st_be;
            end
`endif
            if (w_pop) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    sb_byte_forward #(.DEPTH(DEPTH)) u_fwd (
        .i_ent   (r_ent),
        .i_head  (r_head),
        .i_waddr (w_ld_waddr),
        .o_data  (w_fwd_data),
        .o_mask  (w_fwd_mask)
    );

    assign w_ld_on    = ld_valid && reset;
    assign w_cov      = w_fwd_mask & ld_be;
    assign ld_hit     = w_ld_on && (ld_be != '0) && (w_cov == ld_be);
    assign ld_partial = w_ld_on && (w_cov != '0) && (w_cov != ld_be);

    // Only lanes that are both requested and forwarded carry data.
    always_comb begin
        ld_data = '0;
        for (int l = 0; l < NB; l++)
            if (w_ld_on && w_cov[l]) ld_data[8*l +: 8] = w_fwd_data[8*l +: 8];
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid = 1'b0, ld_valid = 1'b0, mem_ready = 1'b0;
    logic [31:0] st_addr = '0, st_wdata = '0, ld_addr = '0;
    logic [3:0]  st_be = '0, ld_be = '0;
    logic        st_ready, ld_hit, ld_partial, mem_we, empty, full;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    store_buffer #(.XLEN(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_data(ld_data), .ld_hit(ld_hit), .ld_partial(ld_partial),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .count(count), .empty(empty), .full(full)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [29:0] w; logic [31:0] d; logic [3:0] be; } st_t;
    typedef struct { int cnt; logic emp; logic ful; logic rdy; } stat_t;
    typedef struct { logic hit; logic part; logic [31:0] d; } ld_t;
    typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] be; } wr_t;

    st_t   mq[$];      // reference store queue, oldest first
    stat_t stat_q[$];
    ld_t   ld_q[$];
    wr_t   wr_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model predicts this cycle's
    // outputs from the stores it holds, then commits the cycle's effects.
    task automatic cycle(input logic rn, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [3:0] sbe, input logic lv, input logic [31:0] la,
                         input logic [3:0] lbe, input logic mr);
        int          n;
        logic        pop, merge, rdy, found;
        logic [3:0]  cov;
        logic [31:0] ld_d;
        stat_t       s;
        ld_t         l;
        wr_t         w;
        st_t         t;
        @(posedge clk); #1;
        reset = rn; st_valid = sv; st_addr = sa; st_wdata = sd; st_be = sbe;
        ld_valid = lv; ld_addr = la; ld_be = lbe; mem_ready = mr;
        n = mq.size();
        cov = '0; ld_d = '0;
        for (int b = 0; b < 4; b++) begin
            found = 1'b0;
            for (int i = n - 1; i >= 0; i--)
                if (!found && mq[i].w == la[31:2] && mq[i].be[b]) begin
                    found = 1'b1; cov[b] = 1'b1; ld_d[8*b +: 8] = mq[i].d[8*b +: 8];
                end
        end
        cov = cov & lbe;
        for (int b = 0; b < 4; b++) if (!cov[b]) ld_d[8*b +: 8] = 8'h00;
        if (!rn) begin
            s = '{0, 1'b1, 1'b0, 1'b1};
            stat_q.push_back(s);
            l = '{1'b0, 1'b0, 32'h0};
            if (lv) ld_q.push_back(l);
            mq.delete();
        end else begin
            pop   = (n > 0) && mr;
            merge = 1'b0;
            rdy   = (n < DEPTH);
`ifdef STORE_BUFFER_COALESCE_EN
            if (n > 0 && mq[n-1].w == sa[31:2] && !(n == 1 && pop)) begin
                rdy   = 1'b1;
                merge = sv;
            end
`endif
            s = '{n, (n == 0), (n == DEPTH), rdy};
            stat_q.push_back(s);
            if (lv) begin
                l.hit  = (lbe != 4'h0) && (cov == lbe);
                l.part = (cov != 4'h0) && (cov != lbe);
                l.d    = ld_d;
                ld_q.push_back(l);
            end
            if (pop) begin
                w = '{{mq[0].w, 2'b00}, mq[0].d, mq[0].be};
                wr_q.push_back(w);
            end
            if (merge) begin
                t = mq[n-1];
                for (int b = 0; b < 4; b++) if (sbe[b]) t.d[8*b +: 8] = sd[8*b +: 8];
                t.be = t.be | sbe;
                mq[n-1] = t;
            end
            if (pop) void'(mq.pop_front());
            if (sv && rdy && !merge) begin
                t = '{sa[31:2], sd, sbe};
                mq.push_back(t);
            end
        end
    endtask

    task automatic idle(input logic mr);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, mr);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic mr);
        cycle(1'b1, 1'b1, a, d, be, 1'b0, 32'h0, 4'h0, mr);
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] be);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, be, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && mq.size() > 0; k++) idle(1'b1);
        idle(1'b0); #3;
        chk("drained_empty", 32'(empty), 32'h1);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge clk) begin
        stat_t s;
        ld_t   l;
        wr_t   w;
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            chk("count", 32'(count), 32'(s.cnt));
            chk("empty", 32'(empty), 32'(s.emp));
            chk("full", 32'(full), 32'(s.ful));
            chk("st_ready", 32'(st_ready), 32'(s.rdy));
            chk("mem_we", 32'(mem_we), 32'(!s.emp));
        end
        if (ld_valid) begin
            if (ld_q.size() == 0) chk("ld_unexpected", 32'h1, 32'h0);
            else begin
                l = ld_q.pop_front();
                chk("ld_hit", 32'(ld_hit), 32'(l.hit));
                chk("ld_partial", 32'(ld_partial), 32'(l.part));
                chk("ld_data", ld_data, l.d);
            end
        end else begin
            chk("ld_idle", {ld_data[29:0], ld_hit, ld_partial}, 32'h0);
        end
        if (mem_we && mem_ready) begin
            if (wr_q.size() == 0) chk("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
            else begin
                w = wr_q.pop_front();
                chk("mem_addr", mem_addr, w.a);
                chk("mem_wdata", mem_wdata, w.d);
                chk("mem_be", 32'(mem_be), 32'(w.be));
            end
        end
    end

    initial begin
        // reset
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100, 4'hF, 1'b1);
        idle(1'b0); #3;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_full", 32'(full), 32'h0);

        // fill and drain
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), $urandom, 4'hF, 1'b0);
        idle(1'b0); #3;
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_st_ready", 32'(st_ready), 32'h0);
        chk("fill_count", 32'(count), 32'h4);
        push(32'h110, 32'hDEAD_BEEF, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1); #3;
            chk("drain_order", mem_addr, 32'h100 + 32'(4*i));
        end
        idle(1'b0); #3;
        chk("drain_empty", 32'(empty), 32'h1);
        chk("drain_mem_we", 32'(mem_we), 32'h0);

        // youngest wins
        push(32'h200, 32'h1122_3344, 4'hF, 1'b0);
        push(32'h200, 32'hAABB_CCDD, 4'h3, 1'b0);
        load(32'h200, 4'hF); #3;
        chk("young_hit", 32'(ld_hit), 32'h1);
        chk("young_data", ld_data, 32'h1122_CCDD);
        drain();

        // partial
        push(32'h300, 32'h0000_00EE, 4'h1, 1'b0);
        load(32'h300, 4'h3); #3;
        chk("part_flag", 32'(ld_partial), 32'h1);
        chk("part_hit", 32'(ld_hit), 32'h0);
        chk("part_data", ld_data, 32'h0000_00EE);
        load(32'h304, 4'hF); #3;
        chk("miss_flags", {30'h0, ld_hit, ld_partial}, 32'h0);
        drain();

        // simultaneous push/pop at count=2, wrapping the pointers
        push(32'h400, $urandom, 4'hF, 1'b0);
        push(32'h404, $urandom, 4'hF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push(32'h408 + 32'(4*i), $urandom, 4'hF, 1'b1); #3;
            chk("pushpop_count", 32'(count), 32'h2);
        end
        drain();

        // reset mid-operation
        for (int i = 0; i < 3; i++) push(32'h480 + 32'(4*i), $urandom, 4'hF, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1);
        idle(1'b1); #3;
        chk("midrst_empty", 32'(empty), 32'h1);
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        push(32'h700, 32'h5555_AAAA, 4'hF, 1'b0);
        idle(1'b0); #3;
        chk("postrst_count", 32'(count), 32'h1);
        drain();

        // store to the youngest word while full
        for (int i = 0; i < 3; i++) push(32'h500 + 32'(4*i), $urandom, 4'hF, 1'b0);
        push(32'h50C, 32'h0102_0304, 4'h3, 1'b0);
        push(32'h50C, 32'hA0B0_C0D0, 4'hC, 1'b0); #3;
`ifdef STORE_BUFFER_COALESCE_EN
        chk("coal_ready", 32'(st_ready), 32'h1);
`else
        chk("coal_ready", 32'(st_ready), 32'h0);
`endif
        load(32'h50C, 4'hF); #3;
        chk("coal_count", 32'(count), 32'h4);
`ifdef STORE_BUFFER_COALESCE_EN
        chk("coal_data", ld_data, 32'hA0B0_0304);
        chk("coal_hit", 32'(ld_hit), 32'h1);
`else
        chk("coal_data", ld_data, 32'h0000_0304);
        chk("coal_hit", 32'(ld_hit), 32'h0);
`endif
        drain();

        // randomized traffic on a small set of words
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 2) != 0),
                  32'h600 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) != 0),
                  32'h600 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0));
        end
        drain();

        @(negedge clk); #1;
        chk("wr_leftover", 32'(wr_q.size()), 32'h0);
        chk("ld_leftover", 32'(ld_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
